operand_b_sel: RTL and testbench

Parametrised, registered operand-B source selector for the accumulator datapath. It generalises the 2:1 memory-data/immediate mux into a five-source selector with sign/zero extension and forwarding. A 2-entry skid buffer with a valid/ready handshake sits between decode and the ALU stage, so the datapath can be stalled without losing operands.

---
 rtl/operand_b_pkg.sv | 22 ++
 rtl/operand_b_ext.sv | 35 +++
 rtl/operand_b_sel.sv | 107 ++++++++++
 tb/tb_operand_b_sel.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_b_pkg.sv
// Shared constants for the operand-B selector: source select codes and
// the skid-buffer state encoding.
package operand_b_pkg;

  // Source select codes; 5..7 are illegal and yield a zero operand.
  localparam logic [2:0] SEL_DATA = 3'd0;
  localparam logic [2:0] SEL_SEXT = 3'd1;
  localparam logic [2:0] SEL_ZEXT = 3'd2;
  localparam logic [2:0] SEL_FWD  = 3'd3;
  localparam logic [2:0] SEL_ZERO = 3'd4;

  // Skid-buffer occupancy states.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // True for select codes that name a real source.
  function automatic logic sel_is_legal(input logic [2:0] sel);
    return (sel <= SEL_ZERO);
  endfunction

endpackage

// File: rtl/operand_b_ext.sv
// Combinational extend-and-select: picks operand B from one of five
// sources. Extension uses width casts so IMM_W == DATA_W degenerates
// cleanly into a pass-through for both extend modes.
module operand_b_ext
  import operand_b_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 11
) (
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] data,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] fwd,
  output logic [DATA_W-1:0] operand,
  output logic              illegal
);

  // Source mux; illegal codes force zero and raise the illegal flag.
  always_comb begin
    operand = '0;
    illegal = 1'b0;
    case (sel)
      SEL_DATA: operand = data;
      SEL_SEXT: operand = DATA_W'($signed(imm));
      SEL_ZEXT: operand = DATA_W'(imm);
      SEL_FWD:  operand = fwd;
      SEL_ZERO: operand = '0;
      default: begin
        operand = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/operand_b_sel.sv
// Registered operand-B selector with a 2-entry skid buffer between decode
// and the ALU stage.
//
// Handshake: a beat is accepted when i_valid && o_ready, and leaves when
// o_valid && i_ready. o_ready is a register derived from the next buffer
// state only, so it never depends combinationally on i_ready; all outputs
// come straight from flops.
module operand_b_sel
  import operand_b_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_sel,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic [IMM_W-1:0]  i_SIGNAL,
  input  logic [DATA_W-1:0] i_FWD,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_MUL_B,
  output logic              o_illegal
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] operand;
  logic              sel_illegal;
  logic              ready_q;
  logic              illegal_q;
  logic              accept;
  logic              xfer;

  operand_b_ext #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_ext (
    .sel     (i_sel),
    .data    (i_DATA),
    .imm     (i_SIGNAL),
    .fwd     (i_FWD),
    .operand (operand),
    .illegal (sel_illegal)
  );

  assign accept    = i_valid && ready_q;
  assign xfer      = o_valid && i_ready;
  assign o_valid   = (state != ST_EMPTY);
  assign o_ready   = ready_q;
  assign o_MUL_B   = out_q;
  assign o_illegal = illegal_q;

  // Next buffer occupancy from accept/transfer events.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !xfer)      state_nxt = ST_TWO;
        else if (!accept && xfer) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (xfer) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // State and registered ready; ready stays low while held in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_TWO);
    end
  end

  // Output and skid registers; the skid entry refills the output on transfer from TWO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) out_q <= operand;
        ST_ONE: begin
          if (accept && xfer) out_q  <= operand;
          else if (accept)    skid_q <= operand;
        end
        ST_TWO:   if (xfer) out_q <= skid_q;
        default:  out_q <= out_q;
      endcase
    end
  end

  // Sticky illegal-select flag, set only by an accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) illegal_q <= 1'b0;
    else if (accept && sel_illegal) illegal_q <= 1'b1;
  end

endmodule

// File: tb/tb_operand_b_sel.sv
// Bench for operand_b_sel: directed scenarios plus random traffic against
// a queue-based reference model of the selector and its buffering.
module tb_operand_b_sel;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic              ready_out;
  logic [2:0]        sel = '0;
  logic [DATA_W-1:0] data = '0;
  logic [IMM_W-1:0]  sig = '0;
  logic [DATA_W-1:0] fwd = '0;
  logic              valid_out;
  logic              ready_in = 1'b0;
  logic [DATA_W-1:0] mul_b;
  logic              illegal;

  // Equal-width instance: both extend modes must pass the immediate through.
  logic       e_valid = 1'b0;
  logic       e_ready_out;
  logic [2:0] e_sel = '0;
  logic [7:0] e_data = '0;
  logic [7:0] e_sig = '0;
  logic [7:0] e_fwd = '0;
  logic       e_valid_out;
  logic [7:0] e_mul_b;
  logic       e_illegal;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              m_ready = 1'b0;
  logic              m_ill   = 1'b0;

  operand_b_sel #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid_in),
    .o_ready  (ready_out),
    .i_sel    (sel),
    .i_DATA   (data),
    .i_SIGNAL (sig),
    .i_FWD    (fwd),
    .o_valid  (valid_out),
    .i_ready  (ready_in),
    .o_MUL_B  (mul_b),
    .o_illegal(illegal)
  );

  operand_b_sel #(.DATA_W(8), .IMM_W(8)) dut_eq (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (e_valid),
    .o_ready  (e_ready_out),
    .i_sel    (e_sel),
    .i_DATA   (e_data),
    .i_SIGNAL (e_sig),
    .i_FWD    (e_fwd),
    .o_valid  (e_valid_out),
    .i_ready  (1'b1),
    .o_MUL_B  (e_mul_b),
    .o_illegal(e_illegal)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference operand, computed arithmetically from the select rules.
  function automatic logic [DATA_W-1:0] ref_operand(input logic [2:0] s, input logic [DATA_W-1:0] d,
                                                     input logic [IMM_W-1:0] im, input logic [DATA_W-1:0] f);
    longint v;
    case (s)
      3'd0: return d;
      3'd1: begin
        v = longint'(im);
        if (v >= (longint'(1) << (IMM_W - 1))) v = v - (longint'(1) << IMM_W);
        return DATA_W'(v);
      end
      3'd2: return DATA_W'(longint'(im));
      3'd3: return f;
      default: return '0;
    endcase
  endfunction

  task automatic check_all();
    check("ready", 32'(ready_out), 32'(m_ready));
    check("valid", 32'(valid_out), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("mul_b", 32'(mul_b), 32'(exp_q[0]));
    check("illegal", 32'(illegal), 32'(m_ill));
  endtask

  // One cycle: drive inputs, advance the model across the edge, check at negedge.
  task automatic step(input logic v, input logic [2:0] s, input logic [DATA_W-1:0] d,
                      input logic [IMM_W-1:0] im, input logic [DATA_W-1:0] f, input logic r);
    logic acc;
    logic xf;
    valid_in = v; sel = s; data = d; sig = im; fwd = f; ready_in = r;
    acc = rst_n && v && m_ready;
    xf  = rst_n && r && (exp_q.size() > 0);
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_ready = 1'b0;
      m_ill   = 1'b0;
    end else begin
      if (xf) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_operand(s, d, im, f));
        if (s > 3'd4) m_ill = 1'b1;
      end
      m_ready = (exp_q.size() < 2);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int   guard;
    logic [DATA_W-1:0] fv;

    // Reset block
    @(negedge clk);
    check_all();
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    rst_n = 1'b1;
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    check("ready_after_release", 32'(ready_out), 32'd1);

    // Back-to-back selects
    step(1'b1, 3'd0, 16'hF800, '0, '0, 1'b1);
    check("data_f800", 32'(mul_b), 32'h0000_F800);
    check("illegal_clear", 32'(illegal), 32'd0);
    step(1'b1, 3'd1, '0, 11'h400, '0, 1'b1);
    check("sext_400", 32'(mul_b), 32'h0000_FC00);
    step(1'b1, 3'd2, '0, 11'h400, '0, 1'b1);
    check("zext_400", 32'(mul_b), 32'h0000_0400);
    step(1'b1, 3'd1, '0, 11'h3FF, '0, 1'b1);
    check("sext_3ff", 32'(mul_b), 32'h0000_03FF);
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    check("drained", 32'(valid_out), 32'd0);

    // Backpressure: three forwarded beats, consumer stalled then released
    fv = 16'h0001;
    guard = 0;
    while (fv <= 16'h0003 && guard < 40) begin
      logic take;
      take = m_ready;
      step(1'b1, 3'd3, '0, '0, fv, guard >= 4);
      if (guard == 3) begin
        check("bp_hold_0001", 32'(mul_b), 32'h0001);
        check("bp_not_ready", 32'(ready_out), 32'd0);
      end
      if (take) fv++;
      guard++;
    end
    check("bp_guard", 32'(guard < 40), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, '0, '0, '0, 1'b1);

    // Illegal selects
    step(1'b0, 3'd7, '0, '0, '0, 1'b1);
    check("sel7_idle_no_flag", 32'(illegal), 32'd0);
    step(1'b1, 3'd6, 16'h1234, '0, '0, 1'b1);
    check("sel6_zero", 32'(mul_b), 32'h0);
    check("sel6_flag", 32'(illegal), 32'd1);
    step(1'b1, 3'd0, 16'h5555, '0, '0, 1'b1);
    step(1'b1, 3'd4, 16'hFFFF, '0, '0, 1'b1);
    check("sel4_zero", 32'(mul_b), 32'h0);
    check("flag_sticky", 32'(illegal), 32'd1);

    // Equal-width instance: sext and zext are pass-through
    e_valid = 1'b1; e_sel = 3'd1; e_sig = 8'h85;
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    check("eq_sext", 32'(e_mul_b), 32'h85);
    e_sel = 3'd2; e_sig = 8'hF0;
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    check("eq_zext", 32'(e_mul_b), 32'hF0);
    e_valid = 1'b0;

    // Asynchronous reset with two beats buffered
    step(1'b1, 3'd0, 16'hAAAA, '0, '0, 1'b0);
    step(1'b1, 3'd0, 16'hBBBB, '0, '0, 1'b0);
    check("two_buffered", 32'(exp_q.size()), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(valid_out), 32'd0);
    check("async_mul_b", 32'(mul_b), 32'd0);
    check("async_ready", 32'(ready_out), 32'd0);
    check("async_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    step(1'b1, 3'd0, 16'hCCCC, '0, '0, 1'b1);
    rst_n = 1'b1;
    step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    step(1'b1, 3'd0, 16'h1357, '0, '0, 1'b1);
    check("first_after_reset", 32'(mul_b), 32'h1357);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
           11'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, '0, '0, '0, 1'b1);
    check("final_empty", 32'(valid_out), 32'd0);

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
